// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: APB register offsets and parameter limits.
package gpio_bank_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int DB_W_MIN  = 4;
  localparam int DB_W_MAX  = 24;

  localparam logic [6:0] ADDR_DR       = 7'h00;
  localparam logic [6:0] ADDR_DDR      = 7'h04;
  localparam logic [6:0] ADDR_INTEN    = 7'h08;
  localparam logic [6:0] ADDR_INTMASK  = 7'h0C;
  localparam logic [6:0] ADDR_INTTYPE  = 7'h10;
  localparam logic [6:0] ADDR_INTPOL   = 7'h14;
  localparam logic [6:0] ADDR_BOTHEDGE = 7'h18;
  localparam logic [6:0] ADDR_DEBEN    = 7'h1C;
  localparam logic [6:0] ADDR_INTSTAT  = 7'h20;
  localparam logic [6:0] ADDR_RAWSTAT  = 7'h24;
  localparam logic [6:0] ADDR_EOI      = 7'h28;
  localparam logic [6:0] ADDR_EXT      = 7'h2C;
  localparam logic [6:0] ADDR_DBCNT    = 7'h30;

endpackage

// File: rtl/gpio_bank_pin.sv
// One GPIO pin: input synchronizer, tick-sampled debounce, edge detect and
// raw interrupt status.
module gpio_bank_pin (
  input  logic pclk,
  input  logic presetn,
  input  logic gpio_in,
  input  logic tick,
  input  logic deben,
  input  logic bothedge,
  input  logic intpol,
  input  logic inttype,
  input  logic inten,
  input  logic eoi,
  input  logic type_chg,
  output logic sel,
  output logic etb_trig,
  output logic rawstat
);

  logic sync1, sync2, samp, filt, prev, edge_det;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      samp  <= 1'b0;
      filt  <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      // filt only moves when two consecutive tick samples agree
      if (tick) begin
        samp <= sync2;
        if (sync2 == samp) filt <= sync2;
      end
    end
  end

  assign sel = deben ? filt : sync2;

  always_comb begin
    edge_det = 1'b0;
    if (bothedge)    edge_det = sel ^ prev;
    else if (intpol) edge_det = sel & ~prev;
    else             edge_det = ~sel & prev;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prev     <= 1'b0;
      etb_trig <= 1'b0;
      rawstat  <= 1'b0;
    end else begin
      prev     <= sel;
      etb_trig <= edge_det;
      if (type_chg || !inten) rawstat <= 1'b0;
      else if (inttype) begin
        // a new edge outranks a simultaneous EOI so no event is lost
        if (etb_trig) rawstat <= 1'b1;
        else if (eoi) rawstat <= 1'b0;
      end else begin
        rawstat <= (sel == intpol);
      end
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// APB-controlled GPIO bank: register file, shared debounce prescaler and
// WIDTH per-pin event slices.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DB_W  = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [6:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [WIDTH-1:0] gpio_int,
  output logic             gpio_int_flag,
  output logic [WIDTH-1:0] gpio_etb_trig
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || DB_W < DB_W_MIN || DB_W > DB_W_MAX) begin : g_bad_param
    $error("gpio_bank: WIDTH or DB_W out of range");
  end

  logic [WIDTH-1:0] dr, ddr, inten, intmask, inttype, intpol, bothedge, deben;
  logic [WIDTH-1:0] rawstat, intstat, sel, eoi, type_chg, wdat;
  logic [DB_W-1:0]  dbcnt, pre_cnt;
  logic [31:0]      rdata;
  logic             wr, tick;

  assign wr   = psel & penable & pwrite;
  assign wdat = pwdata[WIDTH-1:0];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      dr       <= '0;
      ddr      <= '0;
      inten    <= '0;
      intmask  <= '0;
      inttype  <= '0;
      intpol   <= '0;
      bothedge <= '0;
      deben    <= '0;
      dbcnt    <= '1;
    end else if (wr) begin
      case (paddr)
        ADDR_DR:       dr       <= wdat;
        ADDR_DDR:      ddr      <= wdat;
        ADDR_INTEN:    inten    <= wdat;
        ADDR_INTMASK:  intmask  <= wdat;
        ADDR_INTTYPE:  inttype  <= wdat;
        ADDR_INTPOL:   intpol   <= wdat;
        ADDR_BOTHEDGE: bothedge <= wdat;
        ADDR_DEBEN:    deben    <= wdat;
        ADDR_DBCNT:    dbcnt    <= pwdata[DB_W-1:0];
        default: ;
      endcase
    end
  end

  // Shared prescaler: one tick per DBCNT+1 cycles; reprogramming restarts it.
  assign tick = (pre_cnt == dbcnt);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                        pre_cnt <= '0;
    else if (wr && paddr == ADDR_DBCNT)  pre_cnt <= '0;
    else if (tick)                       pre_cnt <= '0;
    else                                 pre_cnt <= pre_cnt + 1'b1;
  end

  assign eoi      = {WIDTH{wr && paddr == ADDR_EOI}} & wdat;
  assign type_chg = {WIDTH{wr && paddr == ADDR_INTTYPE}} & (wdat ^ inttype);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_bank_pin u_pin (
      .pclk     (pclk),
      .presetn  (presetn),
      .gpio_in  (gpio_in[i]),
      .tick     (tick),
      .deben    (deben[i]),
      .bothedge (bothedge[i]),
      .intpol   (intpol[i]),
      .inttype  (inttype[i]),
      .inten    (inten[i]),
      .eoi      (eoi[i]),
      .type_chg (type_chg[i]),
      .sel      (sel[i]),
      .etb_trig (gpio_etb_trig[i]),
      .rawstat  (rawstat[i])
    );
  end

  assign intstat  = rawstat & ~intmask;
  assign gpio_int = intstat;
  assign gpio_out = dr;
  assign gpio_oe  = ddr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) gpio_int_flag <= 1'b0;
    else          gpio_int_flag <= |intstat;
  end

  always_comb begin
    rdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_DR:       rdata[WIDTH-1:0] = dr;
        ADDR_DDR:      rdata[WIDTH-1:0] = ddr;
        ADDR_INTEN:    rdata[WIDTH-1:0] = inten;
        ADDR_INTMASK:  rdata[WIDTH-1:0] = intmask;
        ADDR_INTTYPE:  rdata[WIDTH-1:0] = inttype;
        ADDR_INTPOL:   rdata[WIDTH-1:0] = intpol;
        ADDR_BOTHEDGE: rdata[WIDTH-1:0] = bothedge;
        ADDR_DEBEN:    rdata[WIDTH-1:0] = deben;
        ADDR_INTSTAT:  rdata[WIDTH-1:0] = intstat;
        ADDR_RAWSTAT:  rdata[WIDTH-1:0] = rawstat;
        ADDR_EXT:      rdata[WIDTH-1:0] = sel;
        ADDR_DBCNT:    rdata[DB_W-1:0]  = dbcnt;
        default: ;
      endcase
    end
  end

  // Bus output is held at 0 while in reset, including DBCNT's all-ones value.
  assign prdata = presetn ? rdata : '0;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed + randomized checks of gpio_bank against a cycle-history model.
module tb_gpio_bank;
  localparam int WIDTH = 32;
  localparam int DB_W  = 16;

  logic              pclk, presetn, psel, penable, pwrite, gpio_int_flag;
  logic [6:0]        paddr;
  logic [31:0]       pwdata, prdata;
  logic [WIDTH-1:0]  gpio_in, gpio_out, gpio_oe, gpio_int, gpio_etb_trig;

  int checks = 0, failures = 0;
  int etb0_cnt = 0, etb5_cnt = 0;

  gpio_bank #(.WIDTH(WIDTH), .DB_W(DB_W)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_int(gpio_int), .gpio_int_flag(gpio_int_flag),
    .gpio_etb_trig(gpio_etb_trig)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    etb0_cnt += int'(gpio_etb_trig[0]);
    etb5_cnt += int'(gpio_etb_trig[5]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Two-phase APB write; the register updates on the second rising edge.
  task automatic apb_wr(input logic [6:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    cyc(1);
    penable = 1'b1;
    cyc(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // prdata is combinational in the setup phase, so a read needs no clock.
  task automatic peek(input logic [6:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    gpio_in = '0;
    presetn = 1'b0;
    cyc(2);
    presetn = 1'b1;
    cyc(1);
  endtask

  logic [31:0] rd;
  logic [31:0] model [13];
  logic [6:0]  rw_addr [9] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h18, 7'h1C, 7'h30};
  logic [31:0] hist [$];

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    gpio_in = '0;
    presetn = 1'b0;
    cyc(2);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_gpio_oe", gpio_oe, 0);
    check("rst_gpio_int", gpio_int, 0);
    check("rst_flag", {31'd0, gpio_int_flag}, 0);
    check("rst_etb", gpio_etb_trig, 0);
    presetn = 1'b1;
    cyc(1);
    peek(7'h30, rd); check("rst_dbcnt", rd, 32'h0000_FFFF);
    peek(7'h00, rd); check("rst_dr", rd, 0);

    // Data/direction registers
    apb_wr(7'h00, 32'hA5A5_0F0F);
    apb_wr(7'h04, 32'hFFFF_0000);
    check("gpio_out", gpio_out, 32'hA5A5_0F0F);
    check("gpio_oe", gpio_oe, 32'hFFFF_0000);
    peek(7'h00, rd); check("rd_dr", rd, 32'hA5A5_0F0F);
    peek(7'h04, rd); check("rd_ddr", rd, 32'hFFFF_0000);
    peek(7'h3C, rd); check("rd_unmapped", rd, 0);
    peek(7'h28, rd); check("rd_eoi_wo", rd, 0);

    // Rising-edge interrupt on pin 3: etb at +3, gpio_int at +4, flag at +5
    apb_wr(7'h08, 32'h8);
    apb_wr(7'h10, 32'h8);
    apb_wr(7'h14, 32'h8);
    apb_wr(7'h1C, 32'h0);
    gpio_in = 32'h8;
    for (int m = 1; m <= 5; m++) begin
      cyc(1);
      check($sformatf("p3_etb_c%0d", m), {31'd0, gpio_etb_trig[3]}, (m == 3) ? 1 : 0);
      check($sformatf("p3_int_c%0d", m), {31'd0, gpio_int[3]}, (m >= 4) ? 1 : 0);
      check($sformatf("p3_flag_c%0d", m), {31'd0, gpio_int_flag}, (m >= 5) ? 1 : 0);
    end
    apb_wr(7'h28, 32'h8);
    check("p3_int_after_eoi", gpio_int, 0);
    cyc(1);
    check("p3_flag_after_eoi", {31'd0, gpio_int_flag}, 0);

    // Both-edge on pin 0, EOI coinciding with second edge's status set
    do_reset();
    apb_wr(7'h10, 32'h1);
    apb_wr(7'h08, 32'h1);
    apb_wr(7'h18, 32'h1);
    rd = 32'(etb0_cnt);
    gpio_in = 32'h1;
    cyc(4);
    peek(7'h24, rd); check("p0_raw_rise", rd, 32'h1);
    apb_wr(7'h28, 32'h1);
    peek(7'h24, rd); check("p0_raw_eoi", rd, 0);
    hist.push_back(32'(etb0_cnt));
    gpio_in = 32'h0;
    cyc(2);
    apb_wr(7'h28, 32'h1);
    peek(7'h24, rd); check("p0_raw_set_wins", rd, 32'h1);
    cyc(2);
    check("p0_etb_pulses", 32'(etb0_cnt) - hist.pop_front() + 1, 2);

    // Debounce on pin 5 with a 4-cycle tick
    do_reset();
    apb_wr(7'h1C, 32'h20);
    apb_wr(7'h30, 32'h3);
    apb_wr(7'h10, 32'h20);
    apb_wr(7'h14, 32'h20);
    apb_wr(7'h08, 32'h20);
    rd = 32'(etb5_cnt);
    hist.push_back(rd);
    gpio_in = 32'h20;
    cyc(2);
    gpio_in = 32'h0;
    cyc(20);
    peek(7'h2C, rd); check("db_glitch_ext", rd & 32'h20, 0);
    peek(7'h24, rd); check("db_glitch_raw", rd, 0);
    check("db_glitch_etb", 32'(etb5_cnt) - hist[0], 0);
    gpio_in = 32'h20;
    cyc(11);
    peek(7'h2C, rd); check("db_pulse_ext", rd & 32'h20, 32'h20);
    cyc(1);
    gpio_in = 32'h0;
    cyc(20);
    check("db_pulse_etb", 32'(etb5_cnt) - hist.pop_front(), 1);
    peek(7'h24, rd); check("db_pulse_raw", rd, 32'h20);
    peek(7'h2C, rd); check("db_after_ext", rd, 0);

    // Level-low interrupt on pin 7, masked then unmasked; then reset mid-write
    do_reset();
    apb_wr(7'h0C, 32'h80);
    apb_wr(7'h08, 32'h80);
    cyc(2);
    peek(7'h24, rd); check("lvl_raw", rd, 32'h80);
    peek(7'h20, rd); check("lvl_intstat_masked", rd, 0);
    check("lvl_flag_masked", {31'd0, gpio_int_flag}, 0);
    apb_wr(7'h0C, 32'h0);
    check("lvl_int_unmasked", gpio_int, 32'h80);
    cyc(1);
    check("lvl_flag_unmasked", {31'd0, gpio_int_flag}, 1);
    apb_wr(7'h00, 32'h1234_5678);
    apb_wr(7'h04, 32'h0000_00FF);
    psel = 1'b1; pwrite = 1'b1; paddr = 7'h00; pwdata = 32'hFFFF_FFFF;
    cyc(1);
    penable = 1'b1;
    #2;
    presetn = 1'b0;
    #1;
    check("mid_rst_out", gpio_out, 0);
    check("mid_rst_oe", gpio_oe, 0);
    check("mid_rst_int", gpio_int, 0);
    check("mid_rst_flag", {31'd0, gpio_int_flag}, 0);
    check("mid_rst_etb", gpio_etb_trig, 0);
    check("mid_rst_prdata", prdata, 0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cyc(2);
    presetn = 1'b1;
    cyc(1);
    peek(7'h00, rd); check("mid_rst_dr_discarded", rd, 0);

    // Random register traffic against a shadow register file
    do_reset();
    for (int k = 0; k < 13; k++) model[k] = 32'h0;
    model[12] = 32'h0000_FFFF;
    for (int k = 0; k < 24; k++) begin
      logic [6:0]  wa, ra;
      logic [31:0] wd;
      wa = rw_addr[$urandom_range(0, 8)];
      ra = rw_addr[$urandom_range(0, 8)];
      wd = $urandom;
      apb_wr(wa, wd);
      model[wa >> 2] = (wa == 7'h30) ? (wd & 32'h0000_FFFF) : wd;
      peek(ra, rd);
      check($sformatf("rand_reg_%02h", ra), rd, model[ra >> 2]);
    end

    // Random pins in both-edge mode: EXT lags 2 cycles, etb is a 3/4-cycle diff
    do_reset();
    apb_wr(7'h18, 32'hFFFF_FFFF);
    hist.delete();
    repeat (4) hist.push_back(32'h0);
    for (int m = 0; m < 40; m++) begin
      peek(7'h2C, rd);
      check($sformatf("rand_ext_%0d", m), rd, hist[m + 2]);
      check($sformatf("rand_etb_%0d", m), gpio_etb_trig, hist[m + 1] ^ hist[m]);
      gpio_in = $urandom;
      hist.push_back(gpio_in);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
